// File: rtl/task_sequencer.sv
// Frame scheduler: runs INIT_TASKS engines once after reset, then loops the rest once per frame.
// Optional watchdog on the WAIT state is enabled by defining TASK_SEQ_TIMEOUT_EN.
module task_sequencer #(
    parameter int NUM_TASKS    = 6,
    parameter int INIT_TASKS   = 2,
    parameter int FRAME_PERIOD = 1700000,
    parameter int WINDOW       = 1000,
    parameter int TIMEOUT      = 65535
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_TASKS-1:0] task_mask,
    input  logic [NUM_TASKS-1:0] done_vec,
    output logic [NUM_TASKS-1:0] start_vec,
    output logic [3:0]           grant,
    output logic                 grant_valid,
    output logic                 draw_window,
    output logic                 frame_tick,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int CW = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
    localparam int IW = $clog2(NUM_TASKS);
    localparam logic [CW-1:0] RELOAD     = CW'(FRAME_PERIOD - 1);
    localparam logic [CW-1:0] WIN        = CW'(WINDOW);
    localparam logic [IW-1:0] FIRST_LOOP = IW'(INIT_TASKS);
    localparam logic [IW-1:0] LAST_TASK  = IW'(NUM_TASKS - 1);

    typedef enum logic [2:0] {BOOT, ISSUE, WAIT, NEXT, SYNC} state_t;

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [CW-1:0] count;
    logic          tick_pending;
    logic          skip;
    logic          wd_expired;

    // frame_tick is registered one count early so it is high exactly while count == 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count       <= RELOAD;
            frame_tick  <= 1'b0;
            draw_window <= 1'b0;
        end else begin
            count       <= (count == '0) ? RELOAD : count - CW'(1);
            frame_tick  <= (count == CW'(1));
            draw_window <= (count < WIN);
        end
    end

    always_comb begin
        skip = (idx >= FIRST_LOOP) && task_mask[idx];
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        start_vec   = '0;
        grant       = 4'hF;
        grant_valid = 1'b0;
        case (state)
            BOOT: begin
                if (INIT_TASKS > 0) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end else begin
                    state_d = SYNC;
                    idx_d   = FIRST_LOOP;
                end
            end
            ISSUE: begin
                if (skip) begin
                    state_d = NEXT;
                end else begin
                    start_vec[idx] = 1'b1;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                grant       = 4'(idx);
                grant_valid = 1'b1;
                if (done_vec[idx] || wd_expired) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx == LAST_TASK) begin
                    idx_d   = FIRST_LOOP;
                    state_d = SYNC;
                end else begin
                    idx_d   = idx + IW'(1);
                    state_d = ISSUE;
                end
            end
            SYNC: begin
                if (tick_pending || frame_tick) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // A tick seen in SYNC is consumed by the exit; elsewhere it is remembered once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= BOOT;
            idx          <= '0;
            tick_pending <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (frame_tick && state != SYNC) begin
                tick_pending <= 1'b1;
                if (tick_pending) begin
                    overrun <= 1'b1;
                end
            end else if (state == SYNC && (tick_pending || frame_tick)) begin
                tick_pending <= 1'b0;
            end
        end
    end

`ifdef TASK_SEQ_TIMEOUT_EN
    logic [15:0] wd;

    always_comb begin
        wd_expired = (state == WAIT) && (wd == 16'(TIMEOUT - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else if (state != WAIT) begin
            wd <= '0;
        end else if (!done_vec[idx]) begin
            if (wd_expired) begin
                timeout_err <= 1'b1;
            end else begin
                wd <= wd + 16'd1;
            end
        end
    end
`else
    always_comb begin
        wd_expired  = 1'b0;
        timeout_err = 1'b0;
    end
`endif

endmodule

// File: tb/tb_task_sequencer.sv
// Directed bench for task_sequencer: NUM_TASKS=4, INIT_TASKS=1, FRAME_PERIOD=50, WINDOW=5.
module tb_task_sequencer;

    localparam int NT  = 4;
    localparam int IT  = 1;
    localparam int FP  = 50;
    localparam int WIN = 5;
`ifdef TASK_SEQ_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 65535;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NT-1:0] task_mask = '0;
    logic [NT-1:0] done_vec = '0;
    logic [NT-1:0] start_vec;
    logic [3:0]    grant;
    logic          grant_valid, draw_window, frame_tick, overrun, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc;
    int delay[NT];
    int cnt[NT];
    logic [NT-1:0] stuck = '0;
    logic [NT-1:0] dn;

    typedef struct {
        int         c;
        logic [3:0] v;
    } ev_t;
    ev_t slog[$];
    int  tick_log[$];
    int  gcnt[16];
    int  bad_grant;

    task_sequencer #(
        .NUM_TASKS(NT),
        .INIT_TASKS(IT),
        .FRAME_PERIOD(FP),
        .WINDOW(WIN),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .task_mask(task_mask),
        .done_vec(done_vec),
        .start_vec(start_vec),
        .grant(grant),
        .grant_valid(grant_valid),
        .draw_window(draw_window),
        .frame_tick(frame_tick),
        .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Engine model: done pulses delay[i] cycles after its start; delay 0 never answers
    always @(negedge clock) begin
        dn = '0;
        for (int i = 0; i < NT; i++) begin
            if (!reset) cnt[i] = -1;
            else if (start_vec[i]) cnt[i] = (delay[i] > 0) ? delay[i] : -1;
            else if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) dn[i] = 1'b1;
            end
        end
        done_vec = dn | stuck;
    end

    always @(negedge clock) begin
        if (reset) begin
            if (start_vec != '0) slog.push_back('{cyc, start_vec});
            if (frame_tick) tick_log.push_back(cyc);
            if (grant_valid) gcnt[grant]++;
            else if (grant !== 4'hF) bad_grant++;
        end
    end

    task automatic apply_reset(input logic [NT-1:0] mask);
        @(negedge clock);
        reset = 1'b0;
        task_mask = mask;
        repeat (3) @(negedge clock);
        slog.delete();
        tick_log.delete();
        for (int i = 0; i < 16; i++) gcnt[i] = 0;
        bad_grant = 0;
        reset = 1'b1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (start_vec !== 4'b0000) begin errors++; $display("FAIL reset_start got %b exp 0000", start_vec); end
        checks++; if (grant !== 4'hF) begin errors++; $display("FAIL reset_grant got %h exp f", grant); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gvalid got %b exp 0", grant_valid); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        checks++; if (draw_window !== 1'b0) begin errors++; $display("FAIL reset_window got %b exp 0", draw_window); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_err); end
    endtask

    task automatic test_reset_mid_task;
        apply_reset('0);
        wait_until(8);
        checks++; if (grant_valid !== 1'b1 || grant !== 4'h1) begin errors++; $display("FAIL mid_wait got gv=%b g=%h exp gv=1 g=1", grant_valid, grant); end
        #2 reset = 1'b0;
        #1;
        checks++; if (grant !== 4'hF || grant_valid !== 1'b0) begin errors++; $display("FAIL mid_abort got gv=%b g=%h exp gv=0 g=f", grant_valid, grant); end
        checks++; if (start_vec !== 4'b0000) begin errors++; $display("FAIL mid_abort_start got %b exp 0000", start_vec); end
    endtask

    task automatic test_boot_sequence;
        int         ec[16];
        logic [3:0] ev[16];
        int         t0;
        apply_reset('0);
        wait_until(240);
        ec[0] = 1;  ev[0] = 4'b0001;
        ec[1] = 6;  ev[1] = 4'b0010;
        ec[2] = 11; ev[2] = 4'b0100;
        ec[3] = 16; ev[3] = 4'b1000;
        for (int k = 1; k <= 4; k++) begin
            ec[3*k+1] = 50*k;      ev[3*k+1] = 4'b0010;
            ec[3*k+2] = 50*k + 5;  ev[3*k+2] = 4'b0100;
            ec[3*k+3] = 50*k + 10; ev[3*k+3] = 4'b1000;
        end
        checks++; if (slog.size() != 16) begin errors++; $display("FAIL boot_count got %0d exp 16", slog.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < slog.size()) begin
                checks++;
                if (slog[i].c != ec[i] || slog[i].v !== ev[i]) begin
                    errors++; $display("FAIL boot_pulse%0d got %b@%0d exp %b@%0d", i, slog[i].v, slog[i].c, ev[i], ec[i]);
                end
            end
        end
        t0 = 0;
        foreach (slog[i]) if (slog[i].v[0]) t0++;
        checks++; if (t0 != 1) begin errors++; $display("FAIL boot_task0_once got %0d exp 1", t0); end
        checks++; if (gcnt[1] != 15) begin errors++; $display("FAIL boot_grant1_cycles got %0d exp 15", gcnt[1]); end
        checks++; if (bad_grant != 0) begin errors++; $display("FAIL boot_idle_grant got %0d exp 0", bad_grant); end
        checks++; if (tick_log.size() != 4) begin errors++; $display("FAIL boot_ticks got %0d exp 4", tick_log.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < tick_log.size()) begin
                checks++;
                if (tick_log[i] != 50*i + 49) begin errors++; $display("FAIL boot_tick%0d got %0d exp %0d", i, tick_log[i], 50*i + 49); end
            end
        end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL boot_no_timeout got %b exp 0", timeout_err); end
    endtask

    task automatic test_limiter;
        logic edw, eft;
        apply_reset('0);
        for (int k = 1; k <= 200; k++) begin
            wait_until(k);
            edw = (k >= 46) && (((k - 46) % 50) < 5);
            eft = ((k % 50) == 49);
            checks++; if (draw_window !== edw) begin errors++; $display("FAIL window@%0d got %b exp %b", k, draw_window, edw); end
            checks++; if (frame_tick !== eft) begin errors++; $display("FAIL tick@%0d got %b exp %b", k, frame_tick, eft); end
        end
    endtask

    task automatic test_stuck_done;
        stuck = 4'b0010;
        apply_reset('0);
        wait_until(40);
        checks++; if (slog.size() != 4) begin errors++; $display("FAIL stuck_count got %0d exp 4", slog.size()); end
        if (slog.size() >= 4) begin
            checks++; if (slog[1].c != 6 || slog[1].v !== 4'b0010) begin errors++; $display("FAIL stuck_start1 got %b@%0d exp 0010@6", slog[1].v, slog[1].c); end
            checks++; if (slog[2].c != 9 || slog[2].v !== 4'b0100) begin errors++; $display("FAIL stuck_start2 got %b@%0d exp 0100@9", slog[2].v, slog[2].c); end
            checks++; if (slog[3].c != 14 || slog[3].v !== 4'b1000) begin errors++; $display("FAIL stuck_start3 got %b@%0d exp 1000@14", slog[3].v, slog[3].c); end
        end
        checks++; if (gcnt[1] != 1) begin errors++; $display("FAIL stuck_grant1_cycles got %0d exp 1", gcnt[1]); end
        stuck = '0;
    endtask

    task automatic test_mask;
        int         ec[7];
        logic [3:0] ev[7];
        apply_reset(4'b0100);
        wait_until(140);
        ec = '{1, 6, 13, 50, 57, 100, 107};
        ev = '{4'b0001, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
        checks++; if (slog.size() != 7) begin errors++; $display("FAIL mask_count got %0d exp 7", slog.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < slog.size()) begin
                checks++;
                if (slog[i].c != ec[i] || slog[i].v !== ev[i]) begin
                    errors++; $display("FAIL mask_pulse%0d got %b@%0d exp %b@%0d", i, slog[i].v, slog[i].c, ev[i], ec[i]);
                end
            end
        end
        checks++; if (gcnt[2] != 0) begin errors++; $display("FAIL mask_grant2 got %0d exp 0", gcnt[2]); end
        task_mask = '0;
    endtask

`ifndef TASK_SEQ_TIMEOUT_EN
    task automatic test_overrun;
        delay[3] = 120;
        apply_reset('0);
        wait_until(60);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_first_tick got %b exp 0", overrun); end
        wait_until(99);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_before got %b exp 0", overrun); end
        wait_until(100);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun); end
        wait_until(140);
        checks++; if (slog.size() != 5) begin errors++; $display("FAIL overrun_count got %0d exp 5", slog.size()); end
        if (slog.size() >= 5) begin
            checks++; if (slog[4].c != 139 || slog[4].v !== 4'b0010) begin errors++; $display("FAIL overrun_resume got %b@%0d exp 0010@139", slog[4].v, slog[4].c); end
        end
        wait_until(200);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", overrun); end
        delay[3] = 3;
    endtask
`else
    task automatic test_timeout;
        delay[2] = 0;
        apply_reset('0);
        wait_until(31);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", timeout_err); end
        wait_until(32);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set got %b exp 1", timeout_err); end
        wait_until(34);
        checks++; if (slog.size() != 4) begin errors++; $display("FAIL timeout_count got %0d exp 4", slog.size()); end
        if (slog.size() >= 4) begin
            checks++; if (slog[3].c != 33 || slog[3].v !== 4'b1000) begin errors++; $display("FAIL timeout_next got %b@%0d exp 1000@33", slog[3].v, slog[3].c); end
        end
        reset = 1'b0;
        #1;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", timeout_err); end
        delay[2] = 3;
    endtask
`endif

    initial begin
        for (int i = 0; i < NT; i++) delay[i] = 3;
        test_reset;
        test_boot_sequence;
        test_limiter;
        test_stuck_done;
        test_mask;
`ifndef TASK_SEQ_TIMEOUT_EN
        test_overrun;
`else
        test_timeout;
`endif
        test_reset_mid_task;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit got running exp finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/task_sequencer.md
Name: task_sequencer

Overview:
- Parametrised top-level frame scheduler for the game loop. Generalises the fixed main FSM to NUM_TASKS engines over a one-hot start/done handshake.
- Runs the first INIT_TASKS engines once after reset (e.g. reset player, level loader). Then loops the remaining engines in index order, once per frame, synchronised to an internal frame limiter.
- Drives an encoded grant index that the datapath uses to steer grid and VGA muxes, plus a VGA write-window strobe.

Parameters:
- NUM_TASKS, 6, total engines; legal range 2..16.
- INIT_TASKS, 2, engines 0..INIT_TASKS-1 run once after reset; legal range 0..NUM_TASKS-1.
- FRAME_PERIOD, 1700000, frame-limiter period in cycles; must be at least 2.
- WINDOW, 1000, cycles per frame with draw_window high; must be less than FRAME_PERIOD.
- TIMEOUT, 65535, watchdog limit in cycles; used only with TASK_SEQ_TIMEOUT_EN.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous, active-low reset.
- task_mask, in, NUM_TASKS, 1 = skip that loop task; ignored for init tasks.
- done_vec, in, NUM_TASKS, done level/pulse from each engine.
- start_vec, out, NUM_TASKS, one-hot single-cycle start pulse.
- grant, out, 4, index of the task currently being waited on.
- grant_valid, out, 1, high while in WAIT.
- draw_window, out, 1, high while limiter count < WINDOW.
- frame_tick, out, 1, one-cycle pulse when limiter reaches 0.
- overrun, out, 1, sticky; set when a loop pass misses a frame tick.
- timeout_err, out, 1, sticky watchdog error.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to BOOT.
  - start_vec=0, grant=4'hF, grant_valid=0, frame_tick=0, overrun=0, timeout_err=0.
  - Limiter loads FRAME_PERIOD-1; draw_window=0; tick_pending=0; idx=0.
- Limiter:
  - Decrements every cycle; at 0, asserts frame_tick and reloads FRAME_PERIOD-1.
  - draw_window = (count < WINDOW), registered.
- FSM states: BOOT, ISSUE, WAIT, NEXT, SYNC.
- BOOT:
  - Next state ISSUE with idx=0 if INIT_TASKS>0, else SYNC with idx=INIT_TASKS.
- ISSUE:
  - Moore output start_vec[idx]=1 for exactly one cycle; next state WAIT.
  - If idx is at least INIT_TASKS and task_mask[idx]=1 (sampled in ISSUE), no start pulse is issued; next state NEXT.
- WAIT:
  - grant=idx, grant_valid=1.
  - done_vec[idx] is sampled only in WAIT. On 1, next state NEXT. Done bits of other indices are ignored.
  - Done asserted in the same cycle as the start pulse is not seen. It must still be high in WAIT.
- NEXT, increment idx:
  - If idx+1 < NUM_TASKS, go to ISSUE.
  - Else wrap idx to INIT_TASKS and go to SYNC.
  - Init tasks are never revisited until reset.
- SYNC:
  - If tick_pending or frame_tick, clear tick_pending and go to ISSUE.
  - Otherwise wait.
- Tick bookkeeping:
  - A frame_tick outside SYNC sets tick_pending.
  - A second tick while tick_pending is already set also sets overrun. Ticks collapse to one pending.
  - A tick in the same cycle as the SYNC exit is consumed; it does not set tick_pending.
- Special cases:
  - All loop tasks masked: each frame cycles ISSUE/NEXT per index, then SYNC. No start pulses are issued.
  - INIT_TASKS = NUM_TASKS-1: only one loop task exists, and idx stays at that task.
- grant outside WAIT = 4'hF.
- Reset mid-task aborts immediately. Engines are reset by the same net.

Optional Feature:
- Macro TASK_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog clears on entry to WAIT and counts each WAIT cycle.
  - When it reaches TIMEOUT without done: set timeout_err (sticky until reset), then go to NEXT as if done was received.
- Undefined:
  - No watchdog logic; WAIT holds indefinitely; timeout_err tied 0.

Test Plan (NUM_TASKS=4, INIT_TASKS=1, FRAME_PERIOD=50, WINDOW=5, done responder 3 cycles after start unless stated):
- Release reset at cycle 0:
  - start_vec=0001 pulses once.
  - Then 0010, 0100, 1000 in order within the first frame.
  - Task 0 never pulses again over 5 frames.
  - Exactly one pass of tasks 1..3 per 50-cycle frame.
- Hold done_vec[1] high before its start (stuck done):
  - Start 0010 still pulses, and WAIT exits on the first WAIT cycle.
  - grant=1 and grant_valid=1 for exactly 1 cycle.
- task_mask=0100:
  - Task 2 never pulses; sequence per frame is 0010 then 1000.
  - grant never equals 2.
- Responder for task 3 delays done 120 cycles:
  - overrun goes to 1 after the second missed tick and stays 1.
  - Loop resumes immediately after done, with no SYNC wait.
- Limiter check:
  - draw_window high for exactly 5 consecutive cycles per 50.
  - frame_tick single-cycle pulse, 50 cycles apart.
- TASK_SEQ_TIMEOUT_EN with TIMEOUT=20, task 2 never done:
  - timeout_err rises 20 cycles after entering WAIT on task 2.
  - start 1000 follows in the next ISSUE.
  - reset=0 clears timeout_err.
